dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single data memory (`dmem`: synchronous write, combinational read) between the pipeline MEM stage (port 0) and a secondary master such as a program loader or DMA engine (port 1). Port 0 normally wins, which keeps pipeline stalls short. A bounded-wait counter guarantees that port 1 is granted within `MAX_WAIT` denied cycles. The block sits between the MEM stage and `dmem` and registers read responses so that each port receives its own data.

## Interface
- `AW`, 32: address width, passed unchanged to `dmem`.
- `DW`, 32: data width.
- `MAX_WAIT`, 4: maximum consecutive denied cycles for port 1 before a forced grant. Legal range 1..15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `p0_req`  in  1  port 0 access request.
- `p0_we`  in  1  port 0 write enable (1 = write, 0 = read).
- `p0_addr`  in  AW  port 0 byte address.
- `p0_wdata`  in  DW  port 0 write data.
- `p0_gnt`  out  1  port 0 access accepted this cycle; low while `p0_req` is high means stall.
- `p0_rvalid`  out  1  port 0 read data valid, one-cycle pulse.
- `p0_rdata`  out  DW  port 0 registered read data.
- `p1_req`, `p1_we`, `p1_addr`, `p1_wdata`, `p1_gnt`, `p1_rvalid`, `p1_rdata`: same meanings as the port 0 signals, for port 1.
- `mem_we`  out  1  to `dmem` `we`.
- `mem_a`  out  AW  to `dmem` `a`.
- `mem_wd`  out  DW  to `dmem` `wd`.
- `mem_rd`  in  DW  from `dmem` `rd`.
- `p1_forced`  out  1  high in a cycle where port 1 is granted by the wait limit rather than by port 0 being idle.

## Operation
- Grant decision is combinational each cycle and one-hot or zero:
  - If `p1_req` and `wait_cnt == MAX_WAIT`, then `p1_gnt = 1` and `p1_forced = 1`.
  - Otherwise, if `p0_req`, then `p0_gnt = 1`.
  - Otherwise, if `p1_req`, then `p1_gnt = 1`.
  - Otherwise, no grant.
- Memory drive:
  - The granted port's `we`, `addr` and `wdata` go to `mem_we`, `mem_a` and `mem_wd`.
  - With no grant, `mem_we = 0`, `mem_a = 0` and `mem_wd = 0`.
  - `mem_we` is never high without a grant.
- `wait_cnt` is a 4-bit register with the following next-state rules, in priority order:
  - Cleared to 0 when `p1_req` is low or `p1_gnt` is high.
  - Incremented when `p1_req` is high and `p1_gnt` is low.
  - Saturates at `MAX_WAIT`.
- Read response:
  - A granted read (`we = 0`) sets that port's `rvalid` for exactly the next cycle.
  - `rdata` captures `mem_rd` on the granting edge.
  - `rdata` holds its value until that port's next read response.
- A granted write produces no `rvalid`. The write commits in `dmem` at the rising edge that ends the grant cycle.
- Requester rules:
  - A requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`.
  - A request is consumed in its grant cycle. Keeping `req` high afterwards is a new request.
- Simultaneous requests with `wait_cnt < MAX_WAIT`: port 0 wins and `wait_cnt` increments.
- No address decoding, alignment check or byte-enable handling is done here; addresses pass through unchanged.

## Timing
- Reset (asynchronous, immediate on `rst_n` low):
  - `wait_cnt = 0`.
  - `p0_rvalid = 0`, `p1_rvalid = 0`.
  - `p0_rdata = 0`, `p1_rdata = 0`.
- Grant outputs and `mem_*` are combinational from inputs and `wait_cnt`, so they are 0 whenever all `req` inputs are 0, including during reset.
- Grant latency is 0 cycles: `gnt` is asserted in the same cycle as `req` when the port wins.
- Read latency is 1 cycle: `rvalid` and `rdata` are valid in the cycle after the grant.
- Worst-case port 1 wait is exactly `MAX_WAIT` denied cycles. The grant comes in the `MAX_WAIT+1`-th cycle of a continuous request.
- Worst-case port 0 stall is 1 cycle per forced port 1 grant.
- Read-after-write across ports: a write granted in cycle N is visible to a read granted in cycle N+1.
- Reset asserted mid-transaction: a pending `rvalid` is dropped and never emitted after reset release.
- `rst_n` deassertion is synchronous to `clk` at system level. The first grant is possible in the first cycle after release.

## Test plan
- Reset with `rst_n = 0` and random requests → `rvalid = 0` and `rdata = 0` on both ports, `wait_cnt = 0`. After release with no requests, `mem_we = 0` and `mem_a = 0`.
- Port 0 writes `32'hAA55AA55` to address 4, then reads address 4 → `p0_gnt` high both cycles. `p0_rvalid` pulses 1 cycle after the read, with `p0_rdata = 32'hAA55AA55`. `p1_rvalid` never rises.
- Both ports request continuously from cycle 0 with `MAX_WAIT = 4`:
  - Port 0 is granted in cycles 0–3.
  - Port 1 is granted in cycle 4 with `p1_forced = 1`.
  - Port 0 is granted again in cycles 5–8.
  - The pattern repeats every 5 cycles.
- Port 1 alone reads address 8 after a port 0 write of `32'h12345678` in the previous cycle → `p1_gnt` is immediate with `p1_forced = 0`. `p1_rdata = 32'h12345678` one cycle later.
- Port 1 waits 3 cycles, drops `req` for 1 cycle, then re-requests while port 0 is busy → `wait_cnt` restarts at 0. The forced grant comes only after 4 new denied cycles.
- `rst_n` pulsed low in the cycle after a granted read → `rvalid` is never seen high and `rdata = 0`. Normal arbitration resumes after release.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter sharing one data memory between the pipeline MEM stage (port 0)
// and a secondary master (port 1). Port 1 waits at most MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          p1_forced
);

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0]    wait_q, wait_d;
    logic          p0_rvalid_q, p0_rvalid_d;
    logic          p1_rvalid_q, p1_rvalid_d;
    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;

    // The wait-limit grant overrides port 0 priority, so it is evaluated first.
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        p1_forced = 1'b0;
        if (p1_req && (wait_q == WAIT_LIMIT)) begin
            p1_gnt    = 1'b1;
            p1_forced = 1'b1;
        end else if (p0_req) begin
            p0_gnt = 1'b1;
        end else if (p1_req) begin
            p1_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (p0_gnt) begin
            mem_we = p0_we;
            mem_a  = p0_addr;
            mem_wd = p0_wdata;
        end else if (p1_gnt) begin
            mem_we = p1_we;
            mem_a  = p1_addr;
            mem_wd = p1_wdata;
        end
    end

    always_comb begin
        wait_d = wait_q;
        if (!p1_req || p1_gnt) begin
            wait_d = 4'd0;
        end else if (wait_q < WAIT_LIMIT) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // Read data is captured on the granting edge and held until the next read response.
    always_comb begin
        p0_rvalid_d = p0_gnt && !p0_we;
        p1_rvalid_d = p1_gnt && !p1_we;
        p0_rdata_d  = p0_rvalid_d ? mem_rd : p0_rdata_q;
        p1_rdata_d  = p1_rvalid_d ? mem_rd : p1_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q      <= 4'd0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            wait_q      <= wait_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for the wait-counter restart and mid-transaction reset.
module tb_dmem_arbiter;

    localparam logic        H = 1'b1;
    localparam logic        L = 1'b0;
    localparam logic [31:0] Z = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, p1_forced;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;

    logic [31:0] mem [0:63];

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        p0_req, p0_we;
        logic [31:0] p0_addr, p0_wdata;
        logic        p1_req, p1_we;
        logic [31:0] p1_addr, p1_wdata;
        logic        e_p0_gnt, e_p1_gnt, e_forced, e_mem_we;
        logic [31:0] e_mem_a, e_mem_wd;
        logic        e_p0_rv;
        logic [31:0] e_p0_rd;
        logic        e_p1_rv;
        logic [31:0] e_p1_rd;
    } vec_t;

    vec_t vq[$];

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .p1_forced(p1_forced)
    );

    // Stand-in dmem: synchronous write, combinational read, word addressed.
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [8:0] p1r_pat;
        logic [8:0] p1g_pat;
        vec_t v;

        // Single-cycle vectors, applied back to back from reset release.
        vq.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,Z,L,Z});
        vq.push_back('{H,H,32'h4,32'hAA55AA55, L,L,Z,Z, H,L,L,H,32'h4,32'hAA55AA55, L,Z,L,Z});
        vq.push_back('{H,L,32'h4,Z, L,L,Z,Z, H,L,L,L,32'h4,Z, L,Z,L,Z});
        vq.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, H,32'hAA55AA55,L,Z});
        vq.push_back('{H,H,32'h8,32'h12345678, L,L,Z,Z, H,L,L,H,32'h8,32'h12345678, L,32'hAA55AA55,L,Z});
        vq.push_back('{L,L,Z,Z, H,L,32'h8,Z, L,H,L,L,32'h8,Z, L,32'hAA55AA55,L,Z});
        vq.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,32'hAA55AA55,H,32'h12345678});
        vq.push_back('{L,L,Z,Z, H,H,32'hC,32'hDEADBEEF, L,H,L,H,32'hC,32'hDEADBEEF, L,32'hAA55AA55,L,32'h12345678});
        // Continuous contention: port 1 forced every 5th cycle.
        for (int k = 0; k < 10; k++) begin
            logic f;
            f = (k % 5 == 4);
            v = '{H,L,32'h4,Z, H,L,32'hC,Z, !f,f,f,L, f ? 32'hC : 32'h4, Z,
                  (k >= 1) && ((k - 1) % 5 != 4), 32'hAA55AA55,
                  (k >= 1) && ((k - 1) % 5 == 4), (k >= 5) ? 32'hDEADBEEF : 32'h12345678};
            vq.push_back(v);
        end
        vq.push_back('{L,L,Z,Z, L,L,Z,Z, L,L,L,L,Z,Z, L,32'hAA55AA55,H,32'hDEADBEEF});

        // Reset with random read requests.
        rst_n = 1'b0;
        drive(L, L, Z, Z, L, L, Z, Z);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            drive(1'($urandom_range(1)), L, 32'($urandom_range(255)), $urandom,
                  1'($urandom_range(1)), L, 32'($urandom_range(255)), $urandom);
            @(negedge clk);
            chk("rst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
            chk("rst_p1_rvalid", {31'b0, p1_rvalid}, 32'd0);
            chk("rst_p0_rdata", p0_rdata, 32'd0);
            chk("rst_p1_rdata", p1_rdata, 32'd0);
            chk("rst_wait_cnt", {28'b0, dut.wait_q}, 32'd0);
        end
        next_cycle();
        drive(L, L, Z, Z, L, L, Z, Z);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            v = vq[i];
            drive(v.p0_req, v.p0_we, v.p0_addr, v.p0_wdata, v.p1_req, v.p1_we, v.p1_addr, v.p1_wdata);
            @(negedge clk);
            chk($sformatf("v%0d_p0_gnt", i), {31'b0, p0_gnt}, {31'b0, v.e_p0_gnt});
            chk($sformatf("v%0d_p1_gnt", i), {31'b0, p1_gnt}, {31'b0, v.e_p1_gnt});
            chk($sformatf("v%0d_p1_forced", i), {31'b0, p1_forced}, {31'b0, v.e_forced});
            chk($sformatf("v%0d_mem_we", i), {31'b0, mem_we}, {31'b0, v.e_mem_we});
            chk($sformatf("v%0d_mem_a", i), mem_a, v.e_mem_a);
            chk($sformatf("v%0d_mem_wd", i), mem_wd, v.e_mem_wd);
            chk($sformatf("v%0d_p0_rvalid", i), {31'b0, p0_rvalid}, {31'b0, v.e_p0_rv});
            chk($sformatf("v%0d_p0_rdata", i), p0_rdata, v.e_p0_rd);
            chk($sformatf("v%0d_p1_rvalid", i), {31'b0, p1_rvalid}, {31'b0, v.e_p1_rv});
            chk($sformatf("v%0d_p1_rdata", i), p1_rdata, v.e_p1_rd);
            next_cycle();
        end

        // Port 1 waits 3, drops for 1, re-requests: forced grant only after 4 new denials.
        p1r_pat = 9'b111110111;
        p1g_pat = 9'b100000000;
        for (int c = 0; c < 9; c++) begin
            drive(H, L, 32'h4, Z, p1r_pat[c], L, 32'h8, Z);
            @(negedge clk);
            chk($sformatf("drop_c%0d_p1_gnt", c), {31'b0, p1_gnt}, {31'b0, p1g_pat[c]});
            chk($sformatf("drop_c%0d_p1_forced", c), {31'b0, p1_forced}, {31'b0, p1g_pat[c]});
            chk($sformatf("drop_c%0d_p0_gnt", c), {31'b0, p0_gnt}, {31'b0, !p1g_pat[c]});
            next_cycle();
        end

        // Reset pulsed in the cycle after a granted read drops the pending response.
        drive(H, L, 32'h4, Z, L, L, Z, Z);
        @(negedge clk);
        chk("mrst_p0_gnt", {31'b0, p0_gnt}, 32'd1);
        next_cycle();
        rst_n = 1'b0;
        drive(L, L, Z, Z, L, L, Z, Z);
        @(negedge clk);
        chk("mrst_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        chk("mrst_p0_rdata", p0_rdata, 32'd0);
        chk("mrst_p1_rdata", p1_rdata, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_rel_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);
        chk("mrst_rel_p0_rdata", p0_rdata, 32'd0);
        next_cycle();
        drive(L, L, Z, Z, H, L, 32'h4, Z);
        @(negedge clk);
        chk("resume_p1_gnt", {31'b0, p1_gnt}, 32'd1);
        chk("resume_p1_forced", {31'b0, p1_forced}, 32'd0);
        next_cycle();
        drive(L, L, Z, Z, L, L, Z, Z);
        @(negedge clk);
        chk("resume_p1_rvalid", {31'b0, p1_rvalid}, 32'd1);
        chk("resume_p1_rdata", p1_rdata, 32'hAA55AA55);
        chk("resume_p0_rvalid", {31'b0, p0_rvalid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
